// File: rtl/etom_skid_reg.sv
`default_nettype none
//==============================================================================
// Module   : etom_skid_reg
// Brief    : Execute-to-Memory pipeline register with a two-entry skid
//            buffer (main + skid), registered ReadyE, synchronous flush and
//            a saturating backpressure-cycle counter.
// Revision : 1.0 - initial release
//==============================================================================
module etom_skid_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    // E-side bundle
    input  logic              ValidE,
    output logic              ReadyE,
    input  logic              RegWriteE,
    input  logic [1:0]        ResultSrcE,
    input  logic              MemWriteE,
    input  logic              MemSignE,
    input  logic [1:0]        MemSizeE,
    input  logic [XLEN-1:0]   ALUResultE,
    input  logic [XLEN-1:0]   WriteDataE,
    input  logic [4:0]        RdE,
    input  logic [XLEN-1:0]   PCPlus4E,
    // Control
    input  logic              FlushM,
    // M-side bundle
    output logic              ValidM,
    input  logic              ReadyM,
    output logic              RegWriteM,
    output logic [1:0]        ResultSrcM,
    output logic              MemWriteM,
    output logic              MemSignM,
    output logic [1:0]        MemSizeM,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [4:0]        RdM,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [CNT_W-1:0]  StallCount
);

    // Packed bundle: 12 bits of control/Rd plus three XLEN-wide data fields.
    localparam int BW = 12 + 3 * XLEN;
    localparam logic [CNT_W-1:0] c_cntMax = '1;

    // Encoding is {main_v, skid_v}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b10,
        S_FULL  = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic              r_readyE;
    logic [BW-1:0]     r_main;
    logic [BW-1:0]     r_skid;
    logic [CNT_W-1:0]  r_stallCount;

    logic [BW-1:0]     w_bundleE;
    logic              w_accept;
    logic              w_xfer;
    logic              w_mainV;
    logic              w_loadMainE;
    logic              w_loadSkid;
    logic              w_skidToMain;
    logic              w_regWriteRaw;
    logic              w_memWriteRaw;

    assign w_bundleE = {RegWriteE, ResultSrcE, MemWriteE, MemSignE, MemSizeE,
                        ALUResultE, WriteDataE, RdE, PCPlus4E};

    assign w_mainV  = r_state[1];
    assign w_accept = ValidE && r_readyE;
    assign w_xfer   = w_mainV && ReadyM;

    // Next-state and load selects; flush empties both entries and drops any accept.
    always_comb begin
        w_stateNext  = r_state;
        w_loadMainE  = 1'b0;
        w_loadSkid   = 1'b0;
        w_skidToMain = 1'b0;
        if (FlushM) begin
            w_stateNext = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_stateNext = S_ONE;
                        w_loadMainE = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && !w_xfer) begin
                        w_stateNext = S_FULL;
                        w_loadSkid  = 1'b1;
                    end else if (w_accept && w_xfer) begin
                        w_loadMainE = 1'b1;
                    end else if (w_xfer) begin
                        w_stateNext = S_EMPTY;
                    end
                end
                S_FULL: begin
                    // ReadyE is low here, so only the drain path exists.
                    if (w_xfer) begin
                        w_stateNext  = S_ONE;
                        w_skidToMain = 1'b1;
                    end
                end
                default: begin
                    w_stateNext = S_EMPTY;
                end
            endcase
        end
    end

    // State register and registered ready (low exactly when skid will be occupied).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_EMPTY;
            r_readyE <= 1'b1;
        end else begin
            r_state  <= w_stateNext;
            r_readyE <= !w_stateNext[0];
        end
    end

    // Data registers; never cleared by flush, only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_loadMainE) begin
                r_main <= w_bundleE;
            end else if (w_skidToMain) begin
                r_main <= r_skid;
            end
            if (w_loadSkid) begin
                r_skid <= w_bundleE;
            end
        end
    end

    // Saturating count of cycles where M holds a valid bundle it has not taken.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stallCount <= '0;
        end else if (w_mainV && !ReadyM && (r_stallCount != c_cntMax)) begin
            r_stallCount <= r_stallCount + 1'b1;
        end
    end

    assign {w_regWriteRaw, ResultSrcM, w_memWriteRaw, MemSignM, MemSizeM,
            ALUResultM, WriteDataM, RdM, PCPlus4M} = r_main;

    // Side-effecting enables must not leak from a stale main entry.
    assign RegWriteM  = w_regWriteRaw && w_mainV;
    assign MemWriteM  = w_memWriteRaw && w_mainV;
    assign ValidM     = w_mainV;
    assign ReadyE     = r_readyE;
    assign StallCount = r_stallCount;

endmodule
`default_nettype wire
